// File: rtl/clear_seq_pkg.sv
// Shared types and width helpers for the staged clear sequencer.
package clear_seq_pkg;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_HOLD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Hold counter must be able to hold the value HOLD itself.
  function automatic int cnt_w(input int hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

  // Stage count runs 0..STAGES inclusive.
  function automatic int stage_w(input int stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/clear_sync.sv
// Release synchronizer: shifts in a constant 1, async-cleared to 0.
module clear_sync #(
  parameter int SYNC_LEN = 2
) (
  input  logic clk,
  input  logic clear,
  output logic sync_out
);

  logic [SYNC_LEN-1:0] chain;

  // Assertion is immediate; release ripples through SYNC_LEN flops.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) chain <= '0;
    else       chain <= {chain[SYNC_LEN-2:0], 1'b1};
  end

  assign sync_out = chain[SYNC_LEN-1];

endmodule

// File: rtl/clear_sequencer.sv
// Drives active-low clears: async assert, synchronized and staged release.
module clear_sequencer
  import clear_seq_pkg::*;
#(
  parameter int STAGES   = 3,
  parameter int HOLD     = 4,
  parameter int SYNC_LEN = 2
) (
  input  logic                          clk,
  input  logic                          clear,
  input  logic                          soft_req,
  output logic [STAGES-1:0]             clear_n,
  output logic                          ready,
  output logic [stage_w(STAGES)-1:0]    stage
);

  localparam int CW = cnt_w(HOLD);
  localparam int SW = stage_w(STAGES);

  logic          sync_out;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          hit;
  logic          last;

  clear_sync #(.SYNC_LEN(SYNC_LEN)) u_sync (
    .clk      (clk),
    .clear    (clear),
    .sync_out (sync_out)
  );

  // Next hold count. The edge that sees sync_out high is the first hold
  // cycle, so bit 0 releases exactly HOLD edges after the synchronizer
  // output rises (edge SYNC_LEN + HOLD after clear drops).
  always_comb begin
    cnt_inc = (state == S_SYNC) ? CW'(1) : cnt + CW'(1);
    hit     = (cnt_inc == CW'(HOLD));
    last    = (stage == SW'(STAGES - 1));
  end

  // Sequencer FSM; every output is a flop so downstream clears never glitch.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state   <= S_SYNC;
      cnt     <= '0;
      stage   <= '0;
      clear_n <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        S_SYNC, S_HOLD: begin
          if (state == S_HOLD || sync_out) begin
            state <= S_HOLD;
            if (hit) begin
              cnt   <= '0;
              stage <= stage + SW'(1);
              for (int i = 0; i < STAGES; i++)
                if (SW'(i) == stage) clear_n[i] <= 1'b1;
              if (last) begin
                state <= S_DONE;
                ready <= 1'b1;
              end
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        S_DONE: begin
          // Soft clear re-runs the staged release without the synchronizer.
          if (soft_req) begin
            state   <= S_HOLD;
            cnt     <= '0;
            stage   <= '0;
            clear_n <= '0;
            ready   <= 1'b0;
          end
        end
        default: state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_clear_sequencer.sv
// Directed bench for clear_sequencer at default parameters.
module tb_clear_sequencer;

  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       clear = 1'b1;
  logic       soft_req = 1'b0;
  logic [2:0] clear_n;
  logic       ready;
  logic [1:0] stage;

  int checks = 0;
  int errors = 0;

  clear_sequencer #(.STAGES(3), .HOLD(4), .SYNC_LEN(2)) dut (
    .clk      (clk),
    .clear    (clear),
    .soft_req (soft_req),
    .clear_n  (clear_n),
    .ready    (ready),
    .stage    (stage)
  );

  always #5 clk = clk_en ? ~clk : clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected outputs at edge e; base is 2 after a clear release, 0 after soft clear.
  function automatic logic [2:0] exp_n(input int e, input int base);
    return {e >= base + 12, e >= base + 8, e >= base + 4};
  endfunction

  function automatic logic [1:0] exp_stage(input int e, input int base);
    logic [2:0] b;
    b = exp_n(e, base);
    return 2'(b[0]) + 2'(b[1]) + 2'(b[2]);
  endfunction

  task automatic sched(input string nm, input int base, input int first, input int last);
    for (int e = first; e <= last; e++) begin
      @(posedge clk); #1;
      chk($sformatf("%s_n_e%0d", nm, e), 32'(clear_n), 32'(exp_n(e, base)));
      chk($sformatf("%s_rdy_e%0d", nm, e), 32'(ready), 32'(e >= base + 12));
      chk($sformatf("%s_stg_e%0d", nm, e), 32'(stage), 32'(exp_stage(e, base)));
    end
  endtask

  // Drop clear in the low phase, well away from the next rising edge.
  task automatic release_clear();
    @(negedge clk); #2;
    clear = 1'b0;
  endtask

  initial begin
    // Power-up: clear held, no clock edge yet.
    #1;
    chk("pwr_n", 32'(clear_n), 32'h0);
    chk("pwr_rdy", 32'(ready), 32'h0);
    chk("pwr_stg", 32'(stage), 32'h0);

    // Full release: 001 @6, 011 @10, 111 + ready @14.
    release_clear();
    sched("rel", 2, 1, 14);

    // Mid-sequence clear between edges 8 and 9.
    clear = 1'b1; #1;
    chk("reclr_n", 32'(clear_n), 32'h0);
    release_clear();
    sched("mid", 2, 1, 8);
    #2 clear = 1'b1; #1;
    chk("mid_async_n", 32'(clear_n), 32'h0);
    chk("mid_async_stg", 32'(stage), 32'h0);
    release_clear();
    sched("mid2", 2, 1, 14);

    // Soft clear accepted at edge E while done.
    @(posedge clk); #1;
    soft_req = 1'b1;
    @(posedge clk); #1;
    soft_req = 1'b0;
    chk("soft_E_n", 32'(clear_n), 32'h0);
    chk("soft_E_rdy", 32'(ready), 32'h0);
    chk("soft_E_stg", 32'(stage), 32'h0);
    sched("soft", 0, 1, 12);

    // soft_req mid-sequence (sampled at edge 8) is ignored.
    clear = 1'b1;
    release_clear();
    sched("ign", 2, 1, 7);
    soft_req = 1'b1;
    sched("ign", 2, 8, 8);
    soft_req = 1'b0;
    sched("ign", 2, 9, 14);

    // Async clear while done, with the clock stopped.
    @(negedge clk);
    clk_en = 1'b0;
    #20;
    chk("stop_pre_rdy", 32'(ready), 32'h1);
    clear = 1'b1; #1;
    chk("stop_n", 32'(clear_n), 32'h0);
    chk("stop_rdy", 32'(ready), 32'h0);
    chk("stop_stg", 32'(stage), 32'h0);
    clk_en = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
